// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
//
// Registered N-input priority encoder / arbiter with a grant/acknowledge
// handshake. It extends the classic 4-to-2 encoder (Ein/Eout/GS) to N
// request lines. Two selection policies are available, and the policy is
// chosen at run time:
//   - fixed priority: the highest requesting index wins
//   - round-robin:    the search starts at a rotating pointer and moves
//                     downward, wrapping from 0 to N-1
// A grant is sticky. It holds until the consumer acknowledges it, Ein
// drops, or reset is asserted.
//
// Ports:
//   clk   in   1  system clock; all state changes on the rising edge
//   rst   in   1  synchronous reset, active-high
//   Ein   in   1  enable in; 0 clears the outputs and aborts a grant
//   I     in   N  request vector, bit k = request from source k
//   mode  in   1  0 = fixed priority, 1 = round-robin
//   ack   in   1  consumer acknowledges the current grant
//   Y     out  W  granted index (registered)
//   valid out  1  Y holds a live grant (registered)
//   GS    out  1  group signal, same as valid (registered)
//   Eout  out  1  Ein=1 with no request present (registered)
// ---------------------------------------------------------------------------
module rr_priority_encoder #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ein,
    input  logic [N-1:0]         I,
    input  logic                 mode,
    input  logic                 ack,
    output logic [$clog2(N)-1:0] Y,
    output logic                 valid,
    output logic                 GS,
    output logic                 Eout
);

    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic           valid_q, valid_d;
    logic           gs_q, gs_d;
    logic           eout_q, eout_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic [W-1:0]   fixedIdx;
    logic [W-1:0]   rrIdx;
    logic [W-1:0]   selIdx;
    logic           anyReq;
    int             rrBest;
    int             rrDist;

    // Candidate selection for both policies. Fixed priority keeps the
    // highest set bit. Round-robin keeps the set bit with the smallest
    // downward distance from ptr, where the distance wraps modulo N. The
    // result is the same as searching from ptr downward with wrap-around.
    always_comb begin
        fixedIdx = '0;
        rrIdx    = '0;
        rrBest   = N;
        rrDist   = 0;
        for (int k = 0; k < N; k++) begin
            if (I[k]) begin
                fixedIdx = W'(k);
                rrDist   = int'(ptr_q) - k;
                if (rrDist < 0) begin
                    rrDist = rrDist + N;
                end
                if (rrDist < rrBest) begin
                    rrBest = rrDist;
                    rrIdx  = W'(k);
                end
            end
        end
        anyReq = |I;
        selIdx = mode ? rrIdx : fixedIdx;
    end

    // Next-state and next-output logic. By default every register holds its
    // value, so a grant stays in place until ack or abort.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        valid_d = valid_q;
        gs_d    = gs_q;
        eout_d  = eout_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                y_d     = '0;
                valid_d = 1'b0;
                gs_d    = 1'b0;
                eout_d  = 1'b0;
                if (Ein) begin
                    if (anyReq) begin
                        y_d     = selIdx;
                        valid_d = 1'b1;
                        gs_d    = 1'b1;
                        state_d = GRANT;
                    end else begin
                        eout_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (!Ein) begin
                    // Abort leaves the round-robin pointer unchanged.
                    y_d     = '0;
                    valid_d = 1'b0;
                    gs_d    = 1'b0;
                    eout_d  = 1'b0;
                    state_d = IDLE;
                end else if (ack) begin
                    // The next round-robin search starts one index below the
                    // index just served. After index 0 it wraps to N-1.
                    ptr_d   = (y_q == '0) ? W'(N - 1) : y_q - W'(1);
                    y_d     = '0;
                    valid_d = 1'b0;
                    gs_d    = 1'b0;
                    eout_d  = ~anyReq;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset takes priority, even in the middle of a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            valid_q <= 1'b0;
            gs_q    <= 1'b0;
            eout_q  <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            gs_q    <= gs_d;
            eout_q  <= eout_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign GS    = gs_q;
    assign Eout  = eout_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_encoder
//
// Scoreboard bench for rr_priority_encoder with N = 8. At each cycle the
// stimulus side drives the inputs and advances a behavioural model of the
// arbiter. It then pushes the expected outputs for the next edge into a
// queue. A separate monitor pops one entry after every rising edge and
// compares it with Y, valid, GS and Eout.
// ---------------------------------------------------------------------------
module tb_rr_priority_encoder;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk;
    logic         rst;
    logic         Ein;
    logic [N-1:0] I;
    logic         mode;
    logic         ack;
    logic [W-1:0] Y;
    logic         valid;
    logic         GS;
    logic         Eout;

    typedef struct packed {
        logic [W-1:0] y;
        logic         valid;
        logic         gs;
        logic         eout;
    } obs_t;

    obs_t expQ[$];
    obs_t expNow;

    int checks = 0;
    int passes = 0;

    // Model state
    bit mGrant = 0;
    int mY     = 0;
    int mPtr   = N - 1;
    bit mEout  = 0;

    rr_priority_encoder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .Ein   (Ein),
        .I     (I),
        .mode  (mode),
        .ack   (ack),
        .Y     (Y),
        .valid (valid),
        .GS    (GS),
        .Eout  (Eout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk the candidate indices in search order: N-1 down to 0 for fixed
    // priority, or ptr downward with wrap-around for round-robin. The first
    // requesting index is returned.
    function automatic int pickIndex(input logic [N-1:0] req, input logic m, input int p);
        int res;
        res = -1;
        for (int s = 0; s < N; s++) begin
            int c;
            c = m ? (p - s + N) % N : (N - 1 - s);
            if (res < 0 && req[c[W-1:0]]) begin
                res = c;
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end else begin
            passes++;
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // and queue the outputs expected after that edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [N-1:0] req,
                                 input logic m, input logic a);
        obs_t o;
        @(negedge clk);
        rst  = r;
        Ein  = e;
        I    = req;
        mode = m;
        ack  = a;
        if (r) begin
            mGrant = 0;
            mY     = 0;
            mEout  = 0;
            mPtr   = N - 1;
        end else if (!mGrant) begin
            mY    = 0;
            mEout = 0;
            if (e) begin
                if (req == '0) begin
                    mEout = 1;
                end else begin
                    mY     = pickIndex(req, m, mPtr);
                    mGrant = 1;
                end
            end
        end else begin
            if (!e) begin
                mGrant = 0;
                mY     = 0;
                mEout  = 0;
            end else if (a) begin
                mPtr   = (mY + N - 1) % N;
                mGrant = 0;
                mY     = 0;
                mEout  = (req == '0);
            end
        end
        o.y     = mY[W-1:0];
        o.valid = mGrant;
        o.gs    = mGrant;
        o.eout  = mEout;
        expQ.push_back(o);
    endtask

    // Monitor: after each rising edge, compare the outputs with the oldest
    // queued expectation.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            expNow = expQ.pop_front();
            checkOutput("Y",     32'(Y),     32'(expNow.y));
            checkOutput("valid", 32'(valid), 32'(expNow.valid));
            checkOutput("GS",    32'(GS),    32'(expNow.gs));
            checkOutput("Eout",  32'(Eout),  32'(expNow.eout));
        end
    end

    initial begin
        rst  = 1'b1;
        Ein  = 1'b1;
        I    = '1;
        mode = 1'b0;
        ack  = 1'b0;

        // Reset held for two cycles with every request active. The first edge
        // after release grants index 7.
        applyStimulus(1, 1, 8'hFF, 0, 0);
        applyStimulus(1, 1, 8'hFF, 0, 0);
        applyStimulus(0, 1, 8'hFF, 0, 0);
        applyStimulus(0, 1, 8'hFF, 0, 1);

        // Fixed priority: hold the grant of 5 with no ack, then acknowledge.
        // The grant of 5 comes back after one idle cycle.
        for (int c = 0; c < 6; c++) applyStimulus(0, 1, 8'b0010_0110, 0, 0);
        applyStimulus(0, 1, 8'b0010_0110, 0, 1);
        applyStimulus(0, 1, 8'b0010_0110, 0, 0);
        applyStimulus(0, 1, 8'b0010_0110, 0, 1);

        // Round-robin with all requests set: grants 7 down to 0, then 7.
        applyStimulus(1, 1, 8'hFF, 1, 0);
        for (int g = 0; g < 9; g++) begin
            applyStimulus(0, 1, 8'hFF, 1, 0);
            applyStimulus(0, 1, 8'hFF, 1, 1);
        end

        // Round-robin between sources 7 and 0. The mode flips to fixed during
        // the grant of 0, and that grant still completes as 0.
        applyStimulus(1, 1, 8'h81, 1, 0);
        applyStimulus(0, 1, 8'h81, 1, 0);
        applyStimulus(0, 1, 8'h81, 1, 1);
        applyStimulus(0, 1, 8'h81, 1, 0);
        applyStimulus(0, 1, 8'h81, 0, 0);
        applyStimulus(0, 1, 8'h81, 0, 1);
        applyStimulus(0, 1, 8'h81, 0, 0);
        applyStimulus(0, 1, 8'h81, 0, 1);

        // No requests raises Eout. A request on source 2 then grants index 2.
        applyStimulus(0, 1, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h04, 0, 0);
        applyStimulus(0, 1, 8'h04, 0, 1);

        // Abort a grant of 3 by dropping Ein. The abort leaves the pointer
        // alone, so round-robin then grants 7.
        applyStimulus(1, 1, 8'h08, 0, 0);
        applyStimulus(0, 1, 8'h08, 0, 0);
        applyStimulus(0, 0, 8'h08, 0, 0);
        applyStimulus(0, 1, 8'hFF, 1, 0);
        applyStimulus(0, 1, 8'hFF, 1, 0);
        applyStimulus(1, 1, 8'hFF, 1, 0);
        applyStimulus(0, 1, 8'hFF, 1, 0);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            logic r, e, m, a;
            logic [N-1:0] req;
            r   = ($urandom_range(0, 39) == 0);
            e   = ($urandom_range(0, 9) != 0);
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            m   = 1'($urandom);
            a   = ($urandom_range(0, 9) < 4);
            applyStimulus(r, e, req, m, a);
        end

        // Let the monitor drain the queue, then confirm that nothing is left.
        applyStimulus(0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #3;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
